// File: rtl/timer_cnt_ctrl.sv
// Timer counter controller: prescaled count enable, debug halt handshake,
// two-step 64-bit TDR load sequencing and sticky compare-match interrupt.
module timer_cnt_ctrl #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halt_req,
  output logic             halt_ack,
  input  logic             load_req,
  input  logic [63:0]      load_val,
  output logic             load_busy,
  output logic [63:0]      tdr,
  output logic             tdr0_wr_en,
  output logic             tdr1_wr_en,
  output logic             cnt_en,
  input  logic             cmp_match,
  input  logic             int_en,
  input  logic             int_clr,
  output logic             int_st,
  output logic             irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_LD0,
    S_LD1,
    S_LDW
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [63:0]      tdr_q, tdr_d;
  logic             cmp_match_q;
  logic             int_st_q, int_st_d;
  state_e           ret_state;
  logic             pre_match;

  // Registered state: FSM, prescaler, load data, interrupt edge detect and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      tdr_q       <= '0;
      cmp_match_q <= 1'b0;
      int_st_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      tdr_q       <= tdr_d;
      cmp_match_q <= cmp_match;
      int_st_q    <= int_st_d;
    end
  end

  // Next state, prescaler and load capture
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    tdr_d     = tdr_q;
    pre_match = (pre_q == div_val);
    // Same resolution serves IDLE/RUN/HALT steady transitions and the LDW return
    if (halt_req)      ret_state = S_HALT;
    else if (timer_en) ret_state = S_RUN;
    else               ret_state = S_IDLE;

    case (state_q)
      S_IDLE, S_RUN, S_HALT: begin
        if (load_req) begin
          state_d = S_LD0;
          tdr_d   = load_val;
        end else begin
          state_d = ret_state;
        end
      end
      S_LD0:   state_d = S_LD1;
      S_LD1:   state_d = S_LDW;
      S_LDW:   state_d = ret_state;
      default: state_d = S_IDLE;
    endcase

    case (state_q)
      S_RUN: begin
        if (!div_en)        pre_d = '0;
        else if (pre_match) pre_d = '0;
        else                pre_d = pre_q + DIV_W'(1);
      end
      S_HALT, S_LD0, S_LD1: pre_d = pre_q;
      default:              pre_d = '0;
    endcase

    // Set wins over a simultaneous clear
    int_st_d = (cmp_match & ~cmp_match_q & timer_en) | (int_st_q & ~int_clr);
  end

  // Output decode from registered state
  always_comb begin
    halt_ack   = (state_q == S_HALT);
    tdr0_wr_en = (state_q == S_LD0);
    tdr1_wr_en = (state_q == S_LD1);
    load_busy  = (state_q == S_LD0) || (state_q == S_LD1) || (state_q == S_LDW);
    cnt_en     = (state_q == S_RUN) && (!div_en || (pre_q == div_val));
    tdr        = tdr_q;
    int_st     = int_st_q;
    irq        = int_st_q & int_en;
  end

endmodule
